// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM memory-test client.
// Holds the FSM state encoding, the data pattern selector codes, the
// checkerboard constants and the error counter saturation value.
package sram_bist_pkg;

  // Test sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // pattern_sel codes
  localparam logic [1:0] PAT_ADDR = 2'd0;  // addr[15:0]
  localparam logic [1:0] PAT_INV  = 2'd1;  // ~addr[15:0]
  localparam logic [1:0] PAT_CHK  = 2'd2;  // checkerboard on addr[0]
  localparam logic [1:0] PAT_SWAP = 2'd3;  // byte-swapped address

  // Checkerboard words for even / odd addresses
  localparam logic [15:0] CHK_EVEN = 16'h5555;
  localparam logic [15:0] CHK_ODD  = 16'hAAAA;

  // Error counter ceiling
  localparam logic [15:0] ERR_SAT = 16'hFFFF;

endpackage

// File: rtl/sram_bist_pattern.sv
// Combinational test-pattern generator.
// Maps the low 16 address bits and a pattern selector to a data word.
// Ports:
//   addr        in  16      low address bits of the location under test
//   pattern_sel in  2       pattern code (see sram_bist_pkg)
//   data        out DATA_W  pattern word, resized to the data bus width
module sram_bist_pattern
  import sram_bist_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       addr,
  input  logic [1:0]        pattern_sel,
  output logic [DATA_W-1:0] data
);

  logic [15:0] pat_s;

  // Select the 16-bit pattern word for this address
  always_comb begin
    pat_s = addr;
    case (pattern_sel)
      PAT_ADDR: pat_s = addr;
      PAT_INV:  pat_s = ~addr;
      PAT_CHK: begin
        if (addr[0]) begin
          pat_s = CHK_ODD;
        end else begin
          pat_s = CHK_EVEN;
        end
      end
      PAT_SWAP: pat_s = {addr[7:0], addr[15:8]};
      default:  pat_s = addr;
    endcase
  end

  assign data = DATA_W'(pat_s);

endmodule

// File: rtl/sram_bist_client.sv
// SRAM memory-test initiator.
// Writes a selectable pattern over [addr_lo..addr_hi] through the SRAM
// controller request interface, reads the range back, and reports pass/fail,
// a saturating mismatch count and the first failing address/data.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start                      one-cycle pulse, ignored while busy
//   pattern_sel, addr_lo/hi    test setup, sampled on start
//   mem, rw, addr, data_f2s    request to the controller (held until accepted)
//   ready                      controller accepts when mem & ready
//   data_s2f_r                 registered read data, valid READ_LAT edges
//                              after read acceptance
//   busy, done, pass           status; done/pass held until next start
//   err_count                  mismatch count, saturating
//   first_err_addr/_data       location and read data of the first mismatch
module sram_bist_client
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  output logic              mem,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_f2s,
  input  logic              ready,
  input  logic [DATA_W-1:0] data_s2f_r,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  // Latency counter starts one below READ_LAT so the compare lands on the
  // edge where the controller's registered data is valid.
  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] cur_r, cur_nxt_s;
  logic [ADDR_W-1:0] lo_r, lo_nxt_s;
  logic [ADDR_W-1:0] hi_r, hi_nxt_s;
  logic [1:0]        sel_r, sel_nxt_s;
  logic [DATA_W-1:0] exp_r, exp_nxt_s;
  logic [ADDR_W-1:0] chk_addr_r, chk_addr_nxt_s;
  logic [2:0]        lat_r, lat_nxt_s;
  logic [15:0]       err_count_r, err_nxt_s;
  logic [ADDR_W-1:0] ferr_addr_r, ferr_addr_nxt_s;
  logic [DATA_W-1:0] ferr_data_r, ferr_data_nxt_s;
  logic              done_r, done_nxt_s;
  logic              pass_r, pass_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              mem_r, mem_nxt_s;
  logic              rw_r, rw_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [DATA_W-1:0] wdata_r, wdata_nxt_s;

  logic              accept_s;
  logic [DATA_W-1:0] wpat_s;
  logic [DATA_W-1:0] epat_s;

  assign accept_s = mem_r & ready;

  // Write data is generated for the address being presented next cycle,
  // so the registered request outputs line up with the registered address.
  sram_bist_pattern #(.DATA_W(DATA_W)) u_wr_pat (
    .addr        (cur_nxt_s[15:0]),
    .pattern_sel (sel_nxt_s),
    .data        (wpat_s)
  );

  // Expected data for the read currently being requested
  sram_bist_pattern #(.DATA_W(DATA_W)) u_exp_pat (
    .addr        (cur_r[15:0]),
    .pattern_sel (sel_r),
    .data        (epat_s)
  );

  // Sequencer: next state, address walk, compare and status bookkeeping
  always_comb begin
    state_nxt_s     = state_r;
    cur_nxt_s       = cur_r;
    lo_nxt_s        = lo_r;
    hi_nxt_s        = hi_r;
    sel_nxt_s       = sel_r;
    exp_nxt_s       = exp_r;
    chk_addr_nxt_s  = chk_addr_r;
    lat_nxt_s       = lat_r;
    err_nxt_s       = err_count_r;
    ferr_addr_nxt_s = ferr_addr_r;
    ferr_data_nxt_s = ferr_data_r;
    done_nxt_s      = done_r;
    pass_nxt_s      = pass_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lo_nxt_s        = addr_lo;
          hi_nxt_s        = addr_hi;
          sel_nxt_s       = pattern_sel;
          cur_nxt_s       = addr_lo;
          err_nxt_s       = 16'h0000;
          ferr_addr_nxt_s = '0;
          ferr_data_nxt_s = '0;
          done_nxt_s      = 1'b0;
          pass_nxt_s      = 1'b0;
          if (addr_lo > addr_hi) begin
            // Empty range: report failure without touching memory
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_WRITE: begin
        if (accept_s) begin
          // Compare before incrementing so hi at the top of the space never wraps
          if (cur_r == hi_r) begin
            cur_nxt_s   = lo_r;
            state_nxt_s = ST_READ;
          end else begin
            cur_nxt_s = cur_r + ADDR_W'(1);
          end
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (accept_s) begin
          exp_nxt_s      = epat_s;
          chk_addr_nxt_s = cur_r;
          lat_nxt_s      = LAT_LOAD;
          state_nxt_s    = ST_RWAIT;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_RWAIT: begin
        if (lat_r == 3'd0) begin
          if (data_s2f_r != exp_r) begin
            if (err_count_r != ERR_SAT) begin
              err_nxt_s = err_count_r + 16'd1;
            end else begin
              err_nxt_s = err_count_r;
            end
            // Count is never zero again once a mismatch has been seen
            if (err_count_r == 16'h0000) begin
              ferr_addr_nxt_s = chk_addr_r;
              ferr_data_nxt_s = data_s2f_r;
            end else begin
              ferr_addr_nxt_s = ferr_addr_r;
            end
          end else begin
            err_nxt_s = err_count_r;
          end
          if (chk_addr_r == hi_r) begin
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
            pass_nxt_s  = (err_nxt_s == 16'h0000);
          end else begin
            cur_nxt_s   = cur_r + ADDR_W'(1);
            state_nxt_s = ST_READ;
          end
        end else begin
          lat_nxt_s = lat_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Request and busy outputs derived from the upcoming state
  always_comb begin
    busy_nxt_s  = (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_READ) ||
                  (state_nxt_s == ST_RWAIT);
    mem_nxt_s   = (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_READ);
    rw_nxt_s    = (state_nxt_s != ST_WRITE);
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    if (mem_nxt_s) begin
      addr_nxt_s = cur_nxt_s;
    end else begin
      addr_nxt_s = addr_r;
    end
    if (state_nxt_s == ST_WRITE) begin
      wdata_nxt_s = wpat_s;
    end else begin
      wdata_nxt_s = wdata_r;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cur_r       <= '0;
      lo_r        <= '0;
      hi_r        <= '0;
      sel_r       <= 2'd0;
      exp_r       <= '0;
      chk_addr_r  <= '0;
      lat_r       <= 3'd0;
      err_count_r <= 16'h0000;
      ferr_addr_r <= '0;
      ferr_data_r <= '0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      busy_r      <= 1'b0;
      mem_r       <= 1'b0;
      rw_r        <= 1'b1;
      addr_r      <= '0;
      wdata_r     <= '0;
    end else begin
      state_r     <= state_nxt_s;
      cur_r       <= cur_nxt_s;
      lo_r        <= lo_nxt_s;
      hi_r        <= hi_nxt_s;
      sel_r       <= sel_nxt_s;
      exp_r       <= exp_nxt_s;
      chk_addr_r  <= chk_addr_nxt_s;
      lat_r       <= lat_nxt_s;
      err_count_r <= err_nxt_s;
      ferr_addr_r <= ferr_addr_nxt_s;
      ferr_data_r <= ferr_data_nxt_s;
      done_r      <= done_nxt_s;
      pass_r      <= pass_nxt_s;
      busy_r      <= busy_nxt_s;
      mem_r       <= mem_nxt_s;
      rw_r        <= rw_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
    end
  end

  assign mem            = mem_r;
  assign rw             = rw_r;
  assign addr           = addr_r;
  assign data_f2s       = wdata_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_count_r;
  assign first_err_addr = ferr_addr_r;
  assign first_err_data = ferr_data_r;

endmodule
